// File: rtl/regfile_pkg.sv
// Shared defaults, typedefs and address qualification for the register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  // An address names a real, writable register: inside the implemented range
  // and not the hardwired zero register.
  function automatic logic addr_ok(input logic [31:0] addr, input int num_regs,
                                   input bit zero_reg);
    return (addr < 32'(num_regs)) && !(zero_reg && (addr == 32'd0));
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: write-first bypass from both writeback ports
// (port 1 last, so it wins), busy lookup against post-update scoreboard.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      reg_val,
  input  logic [1:0]             wb_en,
  input  logic [1:0][ADDR_W-1:0] wb_addr,
  input  logic [1:0][DATA_W-1:0] wb_data,
  input  logic [NUM_REGS-1:0]    busy_nxt,
  output logic [DATA_W-1:0]      data,
  output logic                   busy
);
  logic              ok;
  logic [DATA_W-1:0] val;
  logic              bsy;

  // Bypass mux and busy lookup; unqualified addresses read as zero / idle.
  always_comb begin
    ok  = addr_ok(32'(addr), NUM_REGS, ZERO_REG);
    val = reg_val;
    for (int k = 0; k < 2; k++)
      if (wb_en[k] && (wb_addr[k] == addr)) val = wb_data[k];
    bsy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr == ADDR_W'(i)) bsy = busy_nxt[i];
    if (!ok) begin
      val = '0;
      bsy = 1'b0;
    end
  end

  // Output register; holds when the port is not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      busy <= 1'b0;
    end else if (en) begin
      data <= val;
      busy <= bsy;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with busy scoreboard. Writes land at the edge and
// are bypassed to same-edge reads; issue beats writeback on the busy bit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wb_en,
  input  logic [2*ADDR_W-1:0]      wb_addr,
  input  logic [2*DATA_W-1:0]      wb_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_dest,
  output logic [NUM_REGS-1:0]      busy_vec
);
  logic [DATA_W-1:0]             regs [NUM_REGS];
  logic [NUM_REGS-1:0]           busy, busy_nxt;
  logic [1:0][NUM_REGS-1:0]      wr_hit;
  logic [1:0][ADDR_W-1:0]        wb_a;
  logic [1:0][DATA_W-1:0]        wb_d;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_reg_val;

  assign wb_a     = wb_addr;
  assign wb_d     = wb_data;
  assign busy_vec = busy;

  // Per-register write decode and next scoreboard: clear on writeback,
  // then set on issue so a new producer overrides the retiring one.
  always_comb begin
    wr_hit   = '0;
    busy_nxt = busy;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NUM_REGS; i++)
        if (wb_en[k] && (wb_a[k] == ADDR_W'(i)) && !(ZERO_REG && i == 0)) begin
          wr_hit[k][i] = 1'b1;
          busy_nxt[i]  = 1'b0;
        end
    for (int i = 0; i < NUM_REGS; i++)
      if (iss_valid && (iss_dest == ADDR_W'(i)) && !(ZERO_REG && i == 0))
        busy_nxt[i] = 1'b1;
  end

  // Register array and scoreboard state; port 1 written last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[0][i]) regs[i] <= wb_d[0];
        if (wr_hit[1][i]) regs[i] <= wb_d[1];
      end
      busy <= busy_nxt;
    end
  end

  // Stored value at each read address, before bypass.
  always_comb begin
    rd_reg_val = '0;
    for (int p = 0; p < NUM_RD; p++)
      for (int i = 0; i < NUM_REGS; i++)
        if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) rd_reg_val[p] = regs[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk     (clk),
      .reset   (reset),
      .en      (rd_en[p]),
      .addr    (rd_addr[p*ADDR_W +: ADDR_W]),
      .reg_val (rd_reg_val[p]),
      .wb_en   (wb_en),
      .wb_addr (wb_a),
      .wb_data (wb_d),
      .busy_nxt(busy_nxt),
      .data    (rd_data[p*DATA_W +: DATA_W]),
      .busy    (rd_busy[p])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plan steps followed by random traffic, checked every cycle against
// an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard;
  localparam int DW = 64, AW = 5, NR = 16, NP = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic [1:0]        wb_en;
  logic [2*AW-1:0]   wb_addr;
  logic [2*DW-1:0]   wb_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_dest;
  logic [NR-1:0]     busy_vec;

  int ncmp = 0, nfail = 0;

  // model state, indexed by full address space
  logic [DW-1:0] m_mem  [32];
  bit            m_busy [32];
  logic [DW-1:0] e_data [NP];
  bit            e_busy [NP];

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NP), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic bit valid(input int a);
    return (a < NR) && (a != 0);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; rd_en = '0; rd_addr = '0; wb_en = '0; wb_addr = '0; wb_data = '0;
    iss_valid = 0; iss_dest = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wb(input int k, input int a, input logic [DW-1:0] d);
    wb_en[k] = 1'b1; wb_addr[k*AW +: AW] = AW'(a); wb_data[k*DW +: DW] = d;
  endtask

  task automatic set_iss(input int a);
    iss_valid = 1'b1; iss_dest = AW'(a);
  endtask

  // Apply the architectural rules for one edge using the driven inputs.
  task automatic model_edge();
    int a;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      for (int p = 0; p < NP; p++) begin e_data[p] = '0; e_busy[p] = 0; end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      a = int'(wb_addr[k*AW +: AW]);
      if (wb_en[k] && valid(a)) begin m_mem[a] = wb_data[k*DW +: DW]; m_busy[a] = 0; end
    end
    if (iss_valid && valid(int'(iss_dest))) m_busy[iss_dest] = 1;
    for (int p = 0; p < NP; p++) if (rd_en[p]) begin
      a = int'(rd_addr[p*AW +: AW]);
      e_data[p] = valid(a) ? m_mem[a] : '0;
      e_busy[p] = valid(a) ? m_busy[a] : 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NR-1:0] bv;
    for (int i = 0; i < NR; i++) bv[i] = m_busy[i];
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s.rd_data%0d", tag, p), rd_data[p*DW +: DW], e_data[p]);
      check($sformatf("%s.rd_busy%0d", tag, p), DW'(rd_busy[p]), DW'(e_busy[p]));
    end
    check({tag, ".busy_vec"}, DW'(busy_vec), DW'(bv));
  endtask

  // Inputs were set after a falling edge; clock them in, update model, check.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
    @(negedge clk);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    for (int p = 0; p < NP; p++) begin e_data[p] = '0; e_busy[p] = 0; end
    idle();
    @(negedge clk);
    reset = 1; step("reset0");
    reset = 1; step("reset1");

    set_rd(0, 5); set_rd(1, 31); step("rd_r5_r31");
    set_iss(3); step("iss_r3");
    set_rd(0, 3); step("rd_r3_busy");
    check("plan.r3_busy", DW'(rd_busy[0]), DW'(1));
    set_wb(0, 3, 64'hDEAD_BEEF); set_rd(1, 3); step("wb_r3_bypass");
    check("plan.r3_data", rd_data[DW +: DW], 64'hDEAD_BEEF);
    check("plan.r3_free", DW'(rd_busy[1]), DW'(0));

    set_wb(0, 7, 64'h11); set_wb(1, 7, 64'h22); step("wb_r7_both");
    set_rd(0, 7); step("rd_r7");
    check("plan.r7_port1_wins", rd_data[DW-1:0], 64'h22);

    set_iss(9); set_wb(1, 9, 64'h55); step("iss_wb_r9");
    check("plan.r9_busy_vec", DW'(busy_vec[9]), DW'(1));
    set_rd(1, 9); step("rd_r9");
    check("plan.r9_data", rd_data[DW +: DW], 64'h55);

    set_wb(0, 0, 64'hFFFF); set_iss(0); step("r0_write_issue");
    set_rd(0, 0); set_wb(1, 20, 64'hABCD); step("rd_r0_wb_r20");
    check("plan.r0_zero", rd_data[DW-1:0], 64'h0);
    set_rd(1, 20); step("rd_r20");

    set_wb(0, 4, 64'h1234); set_iss(6); step("wb_r4");
    set_wb(0, 4, 64'h99); set_iss(4); reset = 1; step("reset_mid");
    set_rd(0, 4); set_rd(1, 6); step("rd_after_reset");
    check("plan.r4_after_reset", rd_data[DW-1:0], 64'h0);
    check("plan.busy_after_reset", DW'(busy_vec), DW'(0));

    // random traffic, address range spans out-of-range registers too
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1)) set_wb(k, $urandom_range(0, 20), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) set_iss($urandom_range(0, 20));
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) != 0) set_rd(p, $urandom_range(0, 20));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
